// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO RAM controller: parameter defaults and the
// output-stage FSM state encoding.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AFULL_LVL  = 12;

  // IDLE: no word held, FETCH: RAM read in flight, HOLD: rd_data valid
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// Bundle of push/pop handshakes, attached RAM ports and status flags for
// fifo_ram_ctrl. slave = the controller, master = its parent/environment.
//
// Handshake rule (both push and pop): a word transfers on a rising edge where
// valid and ready are both high; valid never waits on ready, and the producer
// holds data stable while valid is high and ready is low.
interface fifo_ram_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  ram_w_en;
  logic [ADDR_WIDTH-1:0] ram_w_addr;
  logic [DATA_WIDTH-1:0] ram_w_data;

  logic                  ram_r_en;
  logic [ADDR_WIDTH-1:0] ram_r_addr;
  logic [DATA_WIDTH-1:0] ram_r_data;

  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  afull;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_r_data,
    output wr_ready, rd_valid, rd_data,
    output ram_w_en, ram_w_addr, ram_w_data,
    output ram_r_en, ram_r_addr,
    output count, full, empty, afull
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_r_data,
    input  wr_ready, rd_valid, rd_data,
    input  ram_w_en, ram_w_addr, ram_w_data,
    input  ram_r_en, ram_r_addr,
    input  count, full, empty, afull
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointers, occupancy count and registered status flags.
// Pointers carry one extra wrap bit so equal pointers mean "RAM holds no
// unread word". count also includes words in flight or held by the output
// stage, so it is tracked separately from the pointer difference.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LVL  = DEF_AFULL_LVL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  rd_issue,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  ram_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  afull
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0] w_ptr;
  logic [ADDR_WIDTH:0] r_ptr;
  logic [ADDR_WIDTH:0] count_nxt;

  assign w_addr    = w_ptr[ADDR_WIDTH-1:0];
  assign r_addr    = r_ptr[ADDR_WIDTH-1:0];
  assign ram_empty = (w_ptr == r_ptr);

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + ONE_C;
    end else if (pop && !push) begin
      count_nxt = count - ONE_C;
    end
  end

  // Pointers, count and flags; flags derive from the next count so they
  // always match the registered count
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      afull <= 1'b0;
    end else begin
      if (push) begin
        w_ptr <= w_ptr + ONE_C;
      end
      if (rd_issue) begin
        r_ptr <= r_ptr + ONE_C;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      afull <= (count_nxt >= AFULL_C);
    end
  end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Controller for an external synchronous fifo_ram (read data one cycle after
// ram_r_en). Pushes go straight to RAM; a one-word show-ahead output stage
// fetches from RAM and presents the head word on rd_data.
// Optional error flags are built when FIFO_RAM_CTRL_ERR_EN is defined.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LVL  = DEF_AFULL_LVL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  fifo_ram_ctrl_if.slave        bus,
`ifdef FIFO_RAM_CTRL_ERR_EN
  input  logic                  err_clr,
  output logic                  err_ovf,
  output logic                  err_unf,
`endif
  output rd_state_e             dbg_state
);

  rd_state_e             state;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic                  ram_empty;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] fetch_data;

  // wr_ready looks only at the registered full flag, so a pop while full
  // frees a slot for a push on the following cycle
  assign bus.wr_ready = !bus.full && !flush && !rst;
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = bus.rd_valid && bus.rd_ready && !flush && !rst;

  // A new RAM read starts when the output stage is empty or being emptied
  assign rd_issue = !ram_empty && !flush && !rst &&
                    ((state == ST_IDLE) || (state == ST_HOLD && pop));

  assign bus.ram_w_en   = push;
  assign bus.ram_w_addr = w_addr;
  assign bus.ram_w_data = bus.wr_data;
  assign bus.ram_r_en   = rd_issue;
  assign bus.ram_r_addr = r_addr;
  assign fetch_data     = bus.ram_r_data;
  assign dbg_state      = state;

  fifo_ptr_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AFULL_LVL  (AFULL_LVL)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .rd_issue  (rd_issue),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .ram_empty (ram_empty),
    .count     (bus.count),
    .full      (bus.full),
    .empty     (bus.empty),
    .afull     (bus.afull)
  );

  // Output stage FSM; flush drops any in-flight read by returning to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else if (flush) begin
      state        <= ST_IDLE;
      bus.rd_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_issue) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state        <= ST_HOLD;
          bus.rd_valid <= 1'b1;
          bus.rd_data  <= fetch_data;
        end
        ST_HOLD: begin
          if (pop) begin
            state        <= rd_issue ? ST_FETCH : ST_IDLE;
            bus.rd_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.rd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RAM_CTRL_ERR_EN
  // Sticky misuse flags: push attempted while full, pop attempted while empty
  always_ff @(posedge clk) begin
    if (rst || flush || err_clr) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (bus.wr_valid && bus.full) begin
        err_ovf <= 1'b1;
      end
      if (bus.rd_ready && !bus.rd_valid) begin
        err_unf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries in attached fifo_ram.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, log2(FIFO_DEPTH).
REQ-004 SHALL have parameter AFULL_LVL, default 12, almost-full threshold.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  in  1  synchronous discard of all contents.
REQ-008 SHALL have ports wr_valid in 1, wr_ready out 1, wr_data in DATA_WIDTH  push handshake.
REQ-009 SHALL have ports rd_valid out 1, rd_ready in 1, rd_data out DATA_WIDTH  pop handshake, show-ahead.
REQ-010 SHALL have ports ram_w_en out 1, ram_w_addr out ADDR_WIDTH, ram_w_data out DATA_WIDTH  fifo_ram write side.
REQ-011 SHALL have ports ram_r_en out 1, ram_r_addr out ADDR_WIDTH, ram_r_data in DATA_WIDTH  fifo_ram read side, data valid 1 cycle after ram_r_en.
REQ-012 SHALL have ports count out ADDR_WIDTH+1, full out 1, empty out 1, afull out 1  status.

Function
REQ-013 SHALL accept a push when wr_valid & wr_ready; wr_ready = !full & !flush.
REQ-014 SHALL drive ram_w_en/ram_w_addr/ram_w_data combinationally from the accepted push, addr = w_ptr[ADDR_WIDTH-1:0].
REQ-015 SHALL keep w_ptr, r_ptr ADDR_WIDTH+1 bits, incrementing modulo 2*FIFO_DEPTH; RAM-empty = (w_ptr == r_ptr).
REQ-016 SHALL run output FSM states IDLE (no data held), FETCH (ram read in flight), HOLD (rd_data valid).
REQ-017 SHALL issue ram_r_en at r_ptr and increment r_ptr when RAM not empty and (state IDLE, or HOLD with rd_ready, or FETCH with rd_ready-free path: FETCH always -> HOLD).
REQ-018 SHALL transition IDLE->FETCH on read issue; FETCH->HOLD capturing ram_r_data into rd_data; HOLD->IDLE on pop with RAM empty; HOLD->FETCH on pop with read issued; HOLD stays while !rd_ready.
REQ-019 SHALL assert rd_valid only in HOLD; rd_data stable while rd_valid & !rd_ready.
REQ-020 SHALL give latency: push accepted cycle N into empty FIFO -> rd_valid high cycle N+2.
REQ-021 SHALL update count +1 on push, -1 on pop, unchanged on simultaneous push and pop; count includes word held in HOLD.
REQ-022 SHALL set full = (count == FIFO_DEPTH), empty = (count == 0), afull = (count >= AFULL_LVL), all registered-consistent with count.
REQ-023 SHALL, when full, accept a push in the same cycle as a pop only on the following cycle (wr_ready depends on registered count only).
REQ-024 SHALL on flush: pointers, count -> 0, state -> IDLE, rd_valid -> 0, in-flight RAM read discarded; flush overrides simultaneous push/pop.

Reset
REQ-025 SHALL on rst set w_ptr=0, r_ptr=0, count=0, state=IDLE, rd_valid=0, rd_data=0, full=0, empty=1, afull=0, wr_ready=1 after release.
REQ-026 SHALL abandon any operation in progress when rst asserts mid-transfer; no RAM write in a rst cycle.

Configuration
REQ-027 SHALL, with FIFO_RAM_CTRL_ERR_EN defined, add outputs err_ovf, err_unf (1 bit, sticky) and input err_clr; err_ovf sets on wr_valid & full, err_unf sets on rd_ready & !rd_valid; cleared by rst, flush or err_clr.
REQ-028 SHALL, without FIFO_RAM_CTRL_ERR_EN, omit those ports and logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL take FSM state encodings and parameter defaults from shared package fifo_pkg.
REQ-030 SHALL place pointer/count/flag logic in one sub-module fifo_ptr_ctrl; output FSM stays in top.
REQ-031 SHALL not instantiate fifo_ram; connection is at parent level.

Verification
REQ-032 SHALL cover: after rst, push 0xA5 at cycle 0 -> rd_valid=1, rd_data=0xA5 at cycle 2, count=1.
REQ-033 SHALL cover: 16 pushes with rd_ready=0 -> full=1, wr_ready=0, afull set at count 12; 17th wr_valid not accepted.
REQ-034 SHALL cover: continuous push/pop 0x00..0x3F with rd_ready=1 -> order preserved across pointer wrap, count steady.
REQ-035 SHALL cover: flush with 5 entries and a read in flight -> next cycle count=0, empty=1, rd_valid=0; stale word never appears.
REQ-036 SHALL cover: rd_ready toggled randomly while full -> no loss, no duplicate; with FIFO_RAM_CTRL_ERR_EN, push while full -> err_ovf=1 until err_clr.
